// File: rtl/pifo_pkg.sv
// Shared types and tuple layout for the sorted PIFO rank queue.
package pifo_pkg;

    localparam int unsigned RANK_W          = 20;
    localparam int unsigned INFO_W          = 12;
    localparam int unsigned TUPLE_W         = 33;
    localparam int unsigned ENTRY_VALID_BIT = 32;
    localparam int unsigned RANK_LSB        = 12;

    typedef struct packed {
        logic              used;
        logic [RANK_W-1:0] rank;
        logic [INFO_W-1:0] info;
    } pifo_entry_t;

    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_FROM_BELOW,
        SLOT_FROM_ABOVE,
        SLOT_WRITE
    } slot_op_e;

endpackage

// File: rtl/pifo_slot.sv
// One PIFO storage slot: registered entry, next-value mux, and rank-vs-new compare.
module pifo_slot
    import pifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  slot_op_e          op,
    input  pifo_entry_t       below,
    input  pifo_entry_t       above,
    input  pifo_entry_t       wr,
    input  logic [RANK_W-1:0] cmp_rank,
    output pifo_entry_t       entry,
    output logic              le_c
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry <= '0;
        end else begin
            case (op)
                SLOT_FROM_BELOW: entry <= below;
                SLOT_FROM_ABOVE: entry <= above;
                SLOT_WRITE:      entry <= wr;
                default:         entry <= entry;
            endcase
        end
    end

    // Ties compare as "at or before", so equal ranks stay in arrival order.
    assign le_c = entry.used && (entry.rank <= cmp_rank);

endmodule

// File: rtl/pifo_rank_queue.sv
// Sorted push-in-first-out queue: ascending rank, FIFO among equal ranks, min at slot 0.
module pifo_rank_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned RANK_W = pifo_pkg::RANK_W,
    parameter int unsigned INFO_W = pifo_pkg::INFO_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk_dp,
    input  logic                       rst,
    input  logic                       tuple_in_my_pifo_rank_calc_output_VALID,
    input  logic [32:0]                tuple_in_my_pifo_rank_calc_output_DATA,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [RANK_W-1:0]          deq_rank,
    output logic [INFO_W-1:0]          deq_info,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    pifo_pkg::pifo_entry_t slot_q [DEPTH];
    pifo_pkg::pifo_entry_t new_entry;
    pifo_pkg::slot_op_e    op [DEPTH];

    logic [DEPTH-1:0] le;
    logic [DEPTH-1:0] le_lo;
    logic [DEPTH-1:0] le_hi;
    logic [DEPTH-1:0] le_pp;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_next;
    logic             full_q;
    logic             empty_q;
    logic [CNT_W-1:0] drop_q;
    logic             push_req;
    logic             pop;
    logic             push_acc;
    logic             drop;

    assign new_entry.used = 1'b1;
    assign new_entry.rank = tuple_in_my_pifo_rank_calc_output_DATA[pifo_pkg::RANK_LSB +: RANK_W];
    assign new_entry.info = tuple_in_my_pifo_rank_calc_output_DATA[INFO_W-1:0];

    assign push_req = tuple_in_my_pifo_rank_calc_output_VALID
                    && tuple_in_my_pifo_rank_calc_output_DATA[pifo_pkg::ENTRY_VALID_BIT];
    assign pop      = slot_q[0].used && deq_ready;
    assign push_acc = push_req && (!full_q || pop);
    assign drop     = push_req && full_q && !pop;

    // le is a thermometer prefix: its popcount is the insert position.
    assign le_lo = {le[DEPTH-2:0], 1'b1};
    assign le_hi = {1'b0, le[DEPTH-1:1]};
    assign le_pp = {le[DEPTH-1:1], 1'b1};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            op[i] = pifo_pkg::SLOT_HOLD;
            if (push_acc && pop) begin
                // Insert against post-pop contents: position shifts down by one.
                if (le_hi[i])      op[i] = pifo_pkg::SLOT_FROM_ABOVE;
                else if (le_pp[i]) op[i] = pifo_pkg::SLOT_WRITE;
                else               op[i] = pifo_pkg::SLOT_HOLD;
            end else if (push_acc) begin
                if (le[i])         op[i] = pifo_pkg::SLOT_HOLD;
                else if (le_lo[i]) op[i] = pifo_pkg::SLOT_WRITE;
                else               op[i] = pifo_pkg::SLOT_FROM_BELOW;
            end else if (pop) begin
                op[i] = pifo_pkg::SLOT_FROM_ABOVE;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        pifo_pkg::pifo_entry_t below;
        pifo_pkg::pifo_entry_t above;

        if (i == 0) begin : g_below
            assign below = '0;
        end else begin : g_below
            assign below = slot_q[i-1];
        end

        if (i == DEPTH-1) begin : g_above
            assign above = '0;
        end else begin : g_above
            assign above = slot_q[i+1];
        end

        pifo_slot u_slot (
            .clk      (clk_dp),
            .rst      (rst),
            .op       (op[i]),
            .below    (below),
            .above    (above),
            .wr       (new_entry),
            .cmp_rank (new_entry.rank),
            .entry    (slot_q[i]),
            .le_c     (le[i])
        );
    end

    assign occ_next = occ_q + OCC_W'(push_acc) - OCC_W'(pop);

    // Occupancy, flags and saturating drop counter.
    always_ff @(posedge clk_dp) begin
        if (!rst) begin
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            drop_q  <= '0;
        end else begin
            occ_q   <= occ_next;
            full_q  <= (occ_next == OCC_W'(DEPTH));
            empty_q <= (occ_next == '0);
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign deq_valid  = slot_q[0].used;
    assign deq_rank   = slot_q[0].rank;
    assign deq_info   = slot_q[0].info;
    assign occupancy  = occ_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pifo_rank_queue.sv
// Self-checking bench for pifo_rank_queue: queue-based reference model plus directed literal checks.
module tb_pifo_rank_queue;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned RANK_W = 20;
    localparam int unsigned INFO_W = 12;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned OCC_W  = $clog2(DEPTH+1);

    logic              clk_dp = 1'b0;
    logic              rst;
    logic              tvalid;
    logic [32:0]       tdata;
    logic              deq_valid;
    logic              deq_ready;
    logic [RANK_W-1:0] deq_rank;
    logic [INFO_W-1:0] deq_info;
    logic [OCC_W-1:0]  occupancy;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  drop_count;

    always #5 clk_dp = ~clk_dp;

    pifo_rank_queue #(
        .DEPTH  (DEPTH),
        .RANK_W (RANK_W),
        .INFO_W (INFO_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_dp                                  (clk_dp),
        .rst                                     (rst),
        .tuple_in_my_pifo_rank_calc_output_VALID (tvalid),
        .tuple_in_my_pifo_rank_calc_output_DATA  (tdata),
        .deq_valid                               (deq_valid),
        .deq_ready                               (deq_ready),
        .deq_rank                                (deq_rank),
        .deq_info                                (deq_info),
        .occupancy                               (occupancy),
        .full                                    (full),
        .empty                                   (empty),
        .drop_count                              (drop_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [RANK_W-1:0] rank;
        logic [INFO_W-1:0] info;
    } ment_t;

    ment_t             mq[$];
    int unsigned       mdrop = 0;
    logic [RANK_W-1:0] popped_rank[$];
    logic [INFO_W-1:0] popped_info[$];

    // Reference model: a sorted list updated once per clock from the applied inputs.
    always @(posedge clk_dp) begin
        if (!rst) begin
            mq.delete();
            mdrop = 0;
        end else begin
            bit    do_pop;
            bit    do_push;
            ment_t e;
            int    p;
            do_pop  = (mq.size() > 0) && deq_ready;
            do_push = tvalid && tdata[32];
            if (do_pop) begin
                popped_rank.push_back(deq_rank);
                popped_info.push_back(deq_info);
                void'(mq.pop_front());
            end
            if (do_push) begin
                if (mq.size() < DEPTH) begin
                    e.rank = tdata[31:12];
                    e.info = tdata[11:0];
                    p = 0;
                    foreach (mq[k]) if (mq[k].rank <= e.rank) p++;
                    mq.insert(p, e);
                end else if (mdrop < 32'hFFFF) begin
                    mdrop++;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk_dp) begin
        chk("m_deq_valid", 32'(deq_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("m_deq_rank", 32'(deq_rank), 32'(mq[0].rank));
            chk("m_deq_info", 32'(deq_info), 32'(mq[0].info));
        end
        chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
        chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
        chk("m_empty", 32'(empty), 32'(mq.size() == 0));
        chk("m_drop_count", 32'(drop_count), 32'(mdrop));
    end

    // Apply one cycle of inputs, then return just after the following falling edge.
    task automatic cyc(input logic r, input logic v, input logic ev,
                       input int rank, input int info, input logic rdy);
        rst       = r;
        tvalid    = v;
        tdata     = {ev, RANK_W'(rank), INFO_W'(info)};
        deq_ready = rdy;
        @(posedge clk_dp);
        @(negedge clk_dp);
        #1;
    endtask

    task automatic push(input int rank, input int info, input logic rdy);
        cyc(1'b1, 1'b1, 1'b1, rank, info, rdy);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, rdy);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_deq_valid"}, 32'(deq_valid), 0);
        chk({tag, "_deq_rank"}, 32'(deq_rank), 0);
        chk({tag, "_deq_info"}, 32'(deq_info), 0);
        chk({tag, "_occupancy"}, 32'(occupancy), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_drop"}, 32'(drop_count), 0);
    endtask

    initial begin
        rst = 1'b0; tvalid = 1'b0; tdata = '0; deq_ready = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk_reset_values("reset");

        // Ranks 7,3,5 dequeue as 3,5,7.
        push(7, 'h70, 1'b0);
        push(3, 'h30, 1'b0);
        push(5, 'h50, 1'b0);
        chk("t1_occ3", 32'(occupancy), 3);
        chk("t1_head3", 32'(deq_rank), 3);
        popped_rank.delete(); popped_info.delete();
        repeat (3) idle(1'b1);
        idle(1'b0);
        chk("t1_npop", popped_rank.size(), 3);
        if (popped_rank.size() == 3) begin
            chk("t1_pop0", 32'(popped_rank[0]), 3);
            chk("t1_pop1", 32'(popped_rank[1]), 5);
            chk("t1_pop2", 32'(popped_rank[2]), 7);
        end
        chk("t1_empty", 32'(empty), 1);
        chk("t1_occ0", 32'(occupancy), 0);

        // Equal ranks keep arrival order.
        popped_rank.delete(); popped_info.delete();
        push(4, 'h001, 1'b0);
        push(4, 'h002, 1'b0);
        push(2, 'h003, 1'b0);
        repeat (3) idle(1'b1);
        idle(1'b0);
        chk("t2_npop", popped_info.size(), 3);
        if (popped_info.size() == 3) begin
            chk("t2_info0", 32'(popped_info[0]), 'h003);
            chk("t2_info1", 32'(popped_info[1]), 'h001);
            chk("t2_info2", 32'(popped_info[2]), 'h002);
        end

        // Fill, overflow without pop, then overflow with pop.
        for (int i = 0; i < DEPTH; i++) push(2 * i, i, 1'b0);
        chk("t3_full", 32'(full), 1);
        chk("t3_occ16", 32'(occupancy), 16);
        push(100, 'hdd, 1'b0);
        chk("t3_drop1", 32'(drop_count), 1);
        chk("t3_occ_after_drop", 32'(occupancy), 16);
        push(1, 'habc, 1'b1);
        chk("t3_drop_still1", 32'(drop_count), 1);
        chk("t3_occ_pushpop", 32'(occupancy), 16);
        chk("t3_new_head", 32'(deq_rank), 1);
        chk("t3_new_head_info", 32'(deq_info), 'habc);
        repeat (DEPTH) idle(1'b1);
        chk("t3_drained", 32'(empty), 1);

        // Push to empty with deq_ready: accepted, nothing popped.
        push(9, 'h99, 1'b1);
        chk("t4_valid", 32'(deq_valid), 1);
        chk("t4_rank9", 32'(deq_rank), 9);
        for (int r = 10; r < 14; r++) push(r, r, 1'b0);
        chk("t4_occ5", 32'(occupancy), 5);
        popped_rank.delete(); popped_info.delete();
        push(0, 'h0aa, 1'b1);
        chk("t4_head0", 32'(deq_rank), 0);
        chk("t4_occ5_after", 32'(occupancy), 5);
        chk("t4_old_head_left", popped_rank.size(), 1);
        if (popped_rank.size() == 1) chk("t4_popped9", 32'(popped_rank[0]), 9);

        // Tuple without entry_valid is ignored.
        cyc(1'b1, 1'b1, 1'b0, 1, 'h111, 1'b0);
        chk("t5_ignored_occ", 32'(occupancy), 5);
        chk("t5_ignored_drop", 32'(drop_count), 1);
        chk("t5_ignored_head", 32'(deq_rank), 0);

        // Reset with 8 entries stored, even with a push pending.
        for (int r = 20; r < 23; r++) push(r, r, 1'b0);
        chk("t6_occ8", 32'(occupancy), 8);
        cyc(1'b0, 1'b1, 1'b1, 5, 5, 1'b1);
        chk_reset_values("t6_rst");
        idle(1'b0);
        chk("t6_post_empty", 32'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pifo_rank_queue.md
# pifo_rank_queue

Sorted push-in-first-out queue sitting directly downstream of the WRR rank calculator on the data-plane clock. It accepts the calculator's rank tuples, holds them ordered by ascending rank (FIFO among equal ranks), and presents the minimum-rank entry to the egress scheduler through a valid/ready dequeue handshake. Overflow is dropped and counted.

## Interface
- DEPTH, 16, number of entries (≥2)
- RANK_W, 20, rank width (DATA[31:12])
- INFO_W, 12, PIFO info width (DATA[11:0])
- CNT_W, 16, drop counter width
- clk_dp  in  1  data-plane clock; the only clock
- rst  in  1  reset, synchronous, active-low
- tuple_in_my_pifo_rank_calc_output_VALID  in  1  tuple strobe from rank calculator
- tuple_in_my_pifo_rank_calc_output_DATA  in  33  {entry_valid[32], rank[31:12], info[11:0]}
- deq_valid  out  1  head entry present
- deq_ready  in  1  consumer accepts head
- deq_rank  out  RANK_W  rank of head
- deq_info  out  INFO_W  info of head
- occupancy  out  $clog2(DEPTH+1)  stored entries
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- drop_count  out  CNT_W  saturating count of dropped pushes

## Operation
- Storage: DEPTH slots, each {used, rank, info}; slot 0 is head; used slots contiguous from 0, sorted rank ascending.
- Push request = VALID && DATA[32]. VALID with DATA[32]=0 is ignored, not counted.
- Insert position p = number of used slots with rank ≤ new rank (equal ranks keep arrival order). Slots ≥p shift up one; new entry written at p.
- Pop = deq_valid && deq_ready: all slots shift down one.
- Push and pop same cycle: insert position computed against post-pop contents (p-1 if p>0, else 0); occupancy unchanged.
- Full and push without pop: push dropped, drop_count += 1 (saturates at all-ones). Full with pop: push accepted.
- Empty: deq_valid=0; deq_ready ignored; push and deq_ready same cycle → push accepted only.
- Rank comparison unsigned, full RANK_W; no wrap-around handling (calculator guarantees monotonic round space).
- deq_rank/deq_info undefined-but-stable (held slot 0 contents) when deq_valid=0; reset clears to 0.

## Timing
- Reset (rst=0 at clk_dp edge): all slots unused, occupancy=0, empty=1, full=0, deq_valid=0, deq_rank=0, deq_info=0, drop_count=0. Reset mid-operation discards all entries immediately.
- Push latency: entry visible in slot order (and at deq_* if new minimum) the cycle after the VALID edge.
- deq_valid, deq_rank, deq_info, occupancy, full, empty driven straight from registers; no combinational path from deq_ready or input tuple to any output.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Package pifo_pkg: RANK_W, INFO_W defaults, tuple bit-position constants (ENTRY_VALID_BIT=32, RANK_LSB=12), pifo_entry_t struct {used, rank, info}.
- Sub-module pifo_slot: one slot register with compare (rank ≤ new), mux selecting hold / shift-in-from-below / shift-in-from-above / write-new; top level instantiates DEPTH copies and the priority logic.

## Test plan
- Reset then pushes ranks 7,3,5 on consecutive cycles, deq_ready=1 afterward → dequeue order 3,5,7; occupancy 3→0; empty=1 at end.
- Pushes rank 4 info 0x001, rank 4 info 0x002, rank 2 info 0x003 → dequeue info 0x003,0x001,0x002.
- Fill 16 entries, push 17th with no pop → drop_count=1, occupancy=16; repeat with deq_ready=1 same cycle → accepted, drop_count stays 1, occupancy=16.
- Empty queue, push rank 9 with deq_ready=1 same cycle → no pop, next cycle deq_valid=1, deq_rank=9.
- Occupancy 5, push rank 0 with simultaneous pop → old head leaves, new head rank 0, occupancy 5.
- Push DATA[32]=0 tuple → no change, drop_count unchanged; assert rst low with 8 entries stored → next cycle all outputs at reset values.
